multi_lane_serializer: RTL and testbench

Parametrised fabric parallel-to-serial converter for the HDMI/TMDS transmit path. It generalises the fixed 4:1 OSERDES usage to any word width and any lane count. It provides a valid/ready load handshake, a one-word holding buffer and underrun fill with a programmable idle word. It sits between the TMDS encoders (10-bit words per lane) and the output buffers, running entirely in the bit-clock domain.

---
 rtl/ser_pkg.sv | 14 +
 rtl/ser_lane_shift.sv | 33 +++
 rtl/multi_lane_serializer.sv | 177 +++++++++++++++++
 tb/tb_multi_lane_serializer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// Shared types and constants for the multi-lane serializer.
package ser_pkg;

  // Control state: S_IDLE until the first word arrives, then S_RUN until reset.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } ser_state_e;

  // Underrun counter width and its saturation value.
  localparam int                        UNDERRUN_CNT_W   = 16;
  localparam logic [UNDERRUN_CNT_W-1:0] UNDERRUN_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/ser_lane_shift.sv
// One lane's WIDTH-bit load/shift register.
// The serial bit is taken straight from a register bit, so o_bit is registered.
// The register resets to all-INIT so the line idles at INIT until the first load.
module ser_lane_shift #(
  parameter int   WIDTH     = 10,
  parameter int   LSB_FIRST = 1,
  parameter logic INIT      = 1'b0
) (
  input  logic             i_clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_word,
  output logic             o_bit
);

  logic [WIDTH-1:0] r_shreg;

  // Load a new word or advance one bit; vacated positions fill with 0.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg <= {WIDTH{INIT}};
    end else if (i_load) begin
      r_shreg <= i_word;
    end else if (i_shift) begin
      if (LSB_FIRST != 0) r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
      else                r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
    end
  end

  assign o_bit = (LSB_FIRST != 0) ? r_shreg[0] : r_shreg[WIDTH-1];

endmodule

// File: rtl/multi_lane_serializer.sv
// Multi-lane parallel-to-serial converter with valid/ready load, a one-word
// holding buffer and underrun fill with IDLE_WORD. All lanes share one
// handshake, one bit counter and word alignment.
// Optional feature macro: SER_UNDERRUN_CNT_EN adds o_underrun_cnt, a
// saturating count of underrun pulses.
//
// state  | meaning
// S_IDLE | after reset, nothing loaded yet; line holds INIT, no underrun
// S_RUN  | shifting words back to back; IDLE_WORD fills any gap
module multi_lane_serializer
  import ser_pkg::*;
#(
  parameter int               WIDTH     = 10,
  parameter int               LANES     = 3,
  parameter logic             INIT      = 1'b0,
  parameter int               LSB_FIRST = 1,
  parameter logic [WIDTH-1:0] IDLE_WORD = {WIDTH{1'b0}}
) (
  input  logic                   i_clk,
  input  logic                   rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [LANES*WIDTH-1:0] i_data,
  output logic [LANES-1:0]       o_serial,
  output logic                   o_word_start,
  output logic                   o_underrun
`ifdef SER_UNDERRUN_CNT_EN
  ,
  output logic [UNDERRUN_CNT_W-1:0] o_underrun_cnt
`endif
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  ser_state_e              r_state;
  ser_state_e              w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_hold_full;
  logic [LANES*WIDTH-1:0]  r_hold_data;
  logic                    r_word_start;
  logic                    r_underrun;

  logic                    w_last_bit;
  logic                    w_xfer;
  logic                    w_load;
  logic                    w_shift;
  logic                    w_src_hold;
  logic                    w_src_bypass;
  logic                    w_src_idle;
  logic                    w_hold_capture;
  logic                    w_hold_full_nxt;
  logic [LANES*WIDTH-1:0]  w_load_word;

  assign w_last_bit = (r_state == S_RUN) && (r_cnt == LAST_CNT);
  // Registers only: a full buffer frees up exactly when it drains into the shifter.
  assign o_ready    = !r_hold_full || w_last_bit;
  assign w_xfer     = i_valid && o_ready;

  // State register.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state, load event, load source selection and buffer control.
  always_comb begin
    w_state_nxt     = r_state;
    w_load          = 1'b0;
    w_src_hold      = 1'b0;
    w_src_bypass    = 1'b0;
    w_src_idle      = 1'b0;
    w_hold_capture  = 1'b0;
    w_hold_full_nxt = r_hold_full;
    case (r_state)
      S_IDLE: begin
        if (r_hold_full) begin
          w_load          = 1'b1;
          w_src_hold      = 1'b1;
          w_hold_capture  = w_xfer;
          w_hold_full_nxt = w_xfer;
          w_state_nxt     = S_RUN;
        end else if (w_xfer) begin
          w_load       = 1'b1;
          w_src_bypass = 1'b1;
          w_state_nxt  = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last_bit) begin
          w_load = 1'b1;
          if (r_hold_full) begin
            // Buffer drains into the shifter; a same-cycle transfer refills it.
            w_src_hold      = 1'b1;
            w_hold_capture  = w_xfer;
            w_hold_full_nxt = w_xfer;
          end else if (w_xfer) begin
            w_src_bypass = 1'b1;
          end else begin
            w_src_idle = 1'b1;
          end
        end else if (w_xfer) begin
          w_hold_capture  = 1'b1;
          w_hold_full_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_load_word = w_src_hold   ? r_hold_data :
                       w_src_bypass ? i_data      :
                                      {LANES{IDLE_WORD}};
  assign w_shift     = (r_state == S_RUN) && !w_load;

  // Holding buffer.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_full <= 1'b0;
      r_hold_data <= '0;
    end else begin
      r_hold_full <= w_hold_full_nxt;
      if (w_hold_capture) r_hold_data <= i_data;
    end
  end

  // Bit counter: restarts on every load, otherwise advances while running.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n)                  r_cnt <= '0;
    else if (w_load)             r_cnt <= '0;
    else if (r_state == S_RUN)   r_cnt <= r_cnt + 1'b1;
  end

  // Status flags line up with the first bit of the word just loaded.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_start <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_word_start <= w_load;
      r_underrun   <= w_src_idle;
    end
  end

  assign o_word_start = r_word_start;
  assign o_underrun   = r_underrun;

`ifdef SER_UNDERRUN_CNT_EN
  logic [UNDERRUN_CNT_W-1:0] r_underrun_cnt;

  // Saturating underrun count, updated with the pulse it counts.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n)
      r_underrun_cnt <= '0;
    else if (w_src_idle && (r_underrun_cnt != UNDERRUN_CNT_MAX))
      r_underrun_cnt <= r_underrun_cnt + 1'b1;
  end

  assign o_underrun_cnt = r_underrun_cnt;
`endif

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    ser_lane_shift #(
      .WIDTH    (WIDTH),
      .LSB_FIRST(LSB_FIRST),
      .INIT     (INIT)
    ) u_lane (
      .i_clk  (i_clk),
      .rst_n  (rst_n),
      .i_load (w_load),
      .i_shift(w_shift),
      .i_word (w_load_word[k*WIDTH +: WIDTH]),
      .o_bit  (o_serial[k])
    );
  end

endmodule

// File: tb/tb_multi_lane_serializer.sv
// Bench for multi_lane_serializer: directed steps, a word scoreboard fed by the
// driver and drained by a bit-level output monitor, plus an MSB-first instance.
module tb_multi_lane_serializer;
  localparam int         W    = 10;
  localparam int         L    = 3;
  localparam logic [W-1:0] IDLE = 10'h354;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           i_valid = 1'b0;
  logic [L*W-1:0] i_data = '0;
  logic           o_ready, o_word_start, o_underrun;
  logic [L-1:0]   o_serial;

  logic           m_valid = 1'b0;
  logic [L*W-1:0] m_data = '0;
  logic           m_ready, m_ws, m_ur;
  logic [L-1:0]   m_serial;
`ifdef SER_UNDERRUN_CNT_EN
  logic [15:0]    ucnt, m_ucnt;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_xfer = 0;
  logic [L*W-1:0] q[$];

  multi_lane_serializer #(.WIDTH(W), .LANES(L), .INIT(1'b0), .LSB_FIRST(1), .IDLE_WORD(IDLE)) dut (
    .i_clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
    .o_serial(o_serial), .o_word_start(o_word_start), .o_underrun(o_underrun)
`ifdef SER_UNDERRUN_CNT_EN
    , .o_underrun_cnt(ucnt)
`endif
  );

  multi_lane_serializer #(.WIDTH(W), .LANES(L), .INIT(1'b0), .LSB_FIRST(0)) dut_msb (
    .i_clk(clk), .rst_n(rst_n), .i_valid(m_valid), .o_ready(m_ready), .i_data(m_data),
    .o_serial(m_serial), .o_word_start(m_ws), .o_underrun(m_ur)
`ifdef SER_UNDERRUN_CNT_EN
    , .o_underrun_cnt(m_ucnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Offer a word; push it to the scoreboard once the transfer edge has passed.
  task automatic send(input logic [L*W-1:0] d);
    int budget = 200;
    @(negedge clk);
    i_valid = 1'b1;
    i_data  = d;
    while (!o_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("send_ready_timeout", 32'(budget > 0), 32'd1);
    if (budget == 0) i_valid = 1'b0;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    if (budget > 0) q.push_back(d);
    last_xfer = cyc;
  endtask

  task automatic drain();
    int budget = 400;
    while (q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("drain_empty", 32'(q.size()), 32'd0);
    repeat (W + 2) @(negedge clk);
  endtask

  // Output monitor: word alignment, underrun legality and every serial bit.
  logic [L*W-1:0] cur = '0;
  logic [L-1:0]   exp_s;
  int             bitpos = 0;
  bit             running = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      running = 1'b0;
    end else begin
      if (o_underrun) begin
        check("ur_with_start", 32'(o_word_start), 32'd1);
        check("ur_queue_empty", 32'(q.size()), 32'd0);
      end
      if (running) check("word_align", 32'(o_word_start), 32'(bitpos == W));
      if (o_word_start) begin
        if (o_underrun) begin
          cur = {L{IDLE}};
        end else begin
          check("sb_has_word", 32'(q.size() != 0), 32'd1);
          if (q.size() != 0) cur = q.pop_front();
          else               cur = 'x;
        end
        bitpos  = 0;
        running = 1'b1;
      end
      if (running) begin
        for (int k = 0; k < L; k++) exp_s[k] = (bitpos < W) ? cur[k*W + bitpos] : 1'bx;
        check("serial_bits", 32'(o_serial), 32'(exp_s));
        bitpos++;
      end else begin
        check("idle_line", 32'(o_serial), 32'd0);
        check("idle_no_underrun", 32'(o_underrun), 32'd0);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_serial", 32'(o_serial), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_word_start", 32'(o_word_start), 32'd0);
    check("rst_underrun", 32'(o_underrun), 32'd0);
`ifdef SER_UNDERRUN_CNT_EN
    check("rst_ucnt", 32'(ucnt), 32'd0);
`endif
    rst_n = 1'b1;

    // Idle for 50 cycles: ready, INIT on the line, no underrun.
    repeat (50) begin
      @(negedge clk);
      check("idle_ready", 32'(o_ready), 32'd1);
      check("idle_ur", 32'(o_underrun), 32'd0);
    end

    // MSB-first instance: 10'h200 -> 1 then nine 0s.
    @(negedge clk);
    check("msb_ready", 32'(m_ready), 32'd1);
    m_valid = 1'b1;
    m_data  = {10'h000, 10'h000, 10'h200};
    @(posedge clk);
    #1;
    m_valid = 1'b0;
    for (int j = 0; j < W; j++) begin
      @(negedge clk);
      check("msb_bit", 32'(m_serial[0]), 32'(j == 0));
      check("msb_ws", 32'(m_ws), 32'(j == 0));
    end

    // Single word then stop: lane0 2AA, lanes 1/2 3FF; underruns follow.
    send({10'h3FF, 10'h3FF, 10'h2AA});
    @(negedge clk);
    check("first_ws", 32'(o_word_start), 32'd1);
    check("first_bits", 32'(o_serial), 32'b110);
    for (int j = 1; j < W; j++) begin
      @(negedge clk);
      check("first_ws_low", 32'(o_word_start), 32'd0);
      check("first_lane0", 32'(o_serial[0]), 32'(j % 2));
    end
    @(negedge clk);
    check("ur_at_10", 32'(o_underrun), 32'd1);
    check("ur_ws_at_10", 32'(o_word_start), 32'd1);
    repeat (W) @(negedge clk);
    check("ur_at_20", 32'(o_underrun), 32'd1);
    repeat (W) @(negedge clk);
    check("ur_at_30", 32'(o_underrun), 32'd1);
`ifdef SER_UNDERRUN_CNT_EN
    check("ucnt_3", 32'(ucnt), 32'd3);
`endif

    // Resume with a continuous incrementing stream.
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      send({10'(3*i + 12), 10'(3*i + 11), 10'(3*i + 10)});
      if (i >= 3) check("xfer_period", 32'(last_xfer - prev), 32'(W));
      prev = last_xfer;
    end
    drain();

    // Clean restart, then reset mid-word with the buffer full.
    rst_n = 1'b0;
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send({10'h155, 10'h0F0, 10'h3FF});
    send({10'h111, 10'h222, 10'h333});
    @(negedge clk);
    check("hold_full_not_ready", 32'(o_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_lane0", 32'(o_serial[0]), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_serial", 32'(o_serial), 32'd0);
    check("async_rst_ready", 32'(o_ready), 32'd1);
    check("async_rst_ws", 32'(o_word_start), 32'd0);
    check("async_rst_ur", 32'(o_underrun), 32'd0);
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check("post_rst_no_word", 32'(o_word_start), 32'd0);
    end
    send({10'h2C3, 10'h1A5, 10'h0F1});
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
